// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48A1 downstream result path.
// Holds the P-port width and the round-half-up / saturate helper that
// reduces a 48-bit P result to a narrower signed output word.
package dsp_pkg;

    localparam int P_W = 48;

    // Result of round_sat: word is the reduced value sign-extended to P_W
    // bits (callers keep the low OUT_W bits), sat flags a clipped value.
    typedef struct packed {
        logic [P_W-1:0] word;
        logic           sat;
    } rs_t;

    // Round-half-up by discarding 'shift' LSBs, then clip to a signed
    // 'out_w'-bit range. The sum is formed at P_W+1 bits so that adding the
    // half-LSB to the largest positive P cannot wrap.
    function automatic rs_t round_sat(input logic [P_W-1:0] p,
                                      input int             shift,
                                      input int             out_w);
        logic signed [P_W:0] sum;
        logic signed [P_W:0] r;
        logic signed [P_W:0] max_v;
        logic signed [P_W:0] min_v;
        rs_t                 res;
        sum = $signed({p[P_W-1], p});
        if (shift > 0) begin
            sum = sum + (49'sd1 <<< (shift - 1));
        end
        r     = sum >>> shift;
        max_v = (49'sd1 <<< (out_w - 1)) - 49'sd1;
        min_v = -(49'sd1 <<< (out_w - 1));
        res.sat = 1'b1;
        if (r > max_v) begin
            res.word = max_v[P_W-1:0];
        end else if (r < min_v) begin
            res.word = min_v[P_W-1:0];
        end else begin
            res.word = r[P_W-1:0];
            res.sat  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/dsp_result_collector_if.sv
// Signal bundle between the DSP result collector and its neighbours.
//   p, carryout, p_valid : sample from the DSP slice
//   dout, dout_sat, dout_carry, dout_valid, dout_ready : output handshake
//   level, ovf_err, clr_err : occupancy and sticky drop flag control
// master = the surrounding logic, slave = the collector.
interface dsp_result_collector_if #(
    parameter int OUT_W = 24,
    parameter int DEPTH = 8
);
    import dsp_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;

    logic [P_W-1:0]   p;
    logic             carryout;
    logic             p_valid;
    logic [OUT_W-1:0] dout;
    logic             dout_sat;
    logic             dout_carry;
    logic             dout_valid;
    logic             dout_ready;
    logic [LW-1:0]    level;
    logic             ovf_err;
    logic             clr_err;

    modport master (
        output p, carryout, p_valid, dout_ready, clr_err,
        input  dout, dout_sat, dout_carry, dout_valid, level, ovf_err
    );

    modport slave (
        input  p, carryout, p_valid, dout_ready, clr_err,
        output dout, dout_sat, dout_carry, dout_valid, level, ovf_err
    );

endinterface

// File: rtl/dsp_sync_fifo.sv
// Single-clock FIFO with occupancy count.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wdata : write request and data
//   pop/rdata  : read request, head data (combinational from storage)
//   full, empty, level : status
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored, so push+pop on an empty FIFO is push only.
module dsp_sync_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are AW bits so they wrap modulo DEPTH without compare logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + LW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - LW'(1);
            end
        end
    end

endmodule

// File: rtl/dsp_result_collector.sv
// Downstream stage of the DSP48A1 slice: rounds/saturates each valid P
// result to OUT_W bits, registers it, then queues it in a DEPTH-entry FIFO
// with a valid/ready output. Samples arriving at a full FIFO with no pop
// are dropped and flagged on the sticky ovf_err.
//   clk, rst_n : clock, async active-low reset
//   bus        : dsp_result_collector_if slave (sample in, result out,
//                level, ovf_err, clr_err)
module dsp_result_collector
    import dsp_pkg::*;
#(
    parameter int OUT_W = 24,
    parameter int SHIFT = 12,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dsp_result_collector_if.slave   bus
);

    localparam int W  = OUT_W + 2;
    localparam int LW = $clog2(DEPTH) + 1;

    rs_t              rs;
    logic             unused_hi;
    logic             stg_valid;
    logic [OUT_W-1:0] stg_word;
    logic             stg_sat;
    logic             stg_carry;

    logic [W-1:0]     head;
    logic             full;
    logic             empty;
    logic [LW-1:0]    level;
    logic             pop;
    logic             push;
    logic             drop;
    logic             ovf_err;

    always_comb rs = round_sat(bus.p, SHIFT, OUT_W);

    // Upper bits are only the sign extension of the clipped word.
    assign unused_hi = ^rs.word[P_W-1:OUT_W];

    // Stage 1 never stalls; back-pressure is resolved at the FIFO input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg_word  <= '0;
            stg_sat   <= 1'b0;
            stg_carry <= 1'b0;
        end else begin
            stg_valid <= bus.p_valid;
            if (bus.p_valid) begin
                stg_word  <= rs.word[OUT_W-1:0];
                stg_sat   <= rs.sat;
                stg_carry <= bus.carryout;
            end
        end
    end

    assign pop  = bus.dout_ready && !empty;
    assign push = stg_valid && (!full || pop);
    assign drop = stg_valid && full && !pop;

    dsp_sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({stg_word, stg_sat, stg_carry}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (drop) begin
            ovf_err <= 1'b1;
        end else if (bus.clr_err) begin
            ovf_err <= 1'b0;
        end
    end

    // Head fields are forced to zero while empty so stale storage never leaks.
    assign bus.dout       = empty ? '0 : head[W-1:2];
    assign bus.dout_sat   = empty ? 1'b0 : head[1];
    assign bus.dout_carry = empty ? 1'b0 : head[0];
    assign bus.dout_valid = !empty;
    assign bus.level      = level;
    assign bus.ovf_err    = ovf_err;

endmodule

// File: tb/tb_dsp_result_collector.sv
module tb_dsp_result_collector;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    dsp_result_collector_if #(.OUT_W(24), .DEPTH(8)) bus ();

    dsp_result_collector #(
        .OUT_W (24),
        .SHIFT (12),
        .DEPTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.p = '0; bus.carryout = 0; bus.p_valid = 0;
        bus.dout_ready = 0; bus.clr_err = 0;
        rst_n = 0;
        #3;
        n_tests++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus.level); end
        n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.dout_valid); end
        n_tests++; if (bus.ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.ovf_err); end
        n_tests++; if ({bus.dout, bus.dout_sat, bus.dout_carry} !== 26'd0) begin n_fail++; $display("FAIL reset_dout got %h want 0", bus.dout); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_rounding();
        logic [47:0] vp [3];
        logic [23:0] vd [3];
        vp = '{48'h1800, 48'h17FF, 48'h32};
        vd = '{24'h2, 24'h1, 24'h0};
        for (int i = 0; i < 3; i++) begin
            bus.p = vp[i]; bus.carryout = 0; bus.p_valid = 1;
            tick();
            bus.p_valid = 0;
            n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL round_early_valid[%0d] got %b want 0", i, bus.dout_valid); end
            tick();
            n_tests++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL round_valid[%0d] got %b want 1", i, bus.dout_valid); end
            n_tests++; if (bus.dout !== vd[i]) begin n_fail++; $display("FAIL round_dout[%0d] got %h want %h", i, bus.dout, vd[i]); end
            n_tests++; if (bus.dout_sat !== 1'b0) begin n_fail++; $display("FAIL round_sat[%0d] got %b want 0", i, bus.dout_sat); end
            bus.dout_ready = 1;
            tick();
            bus.dout_ready = 0;
            n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL round_pop[%0d] valid got %b want 0", i, bus.dout_valid); end
        end
    endtask

    task automatic test_saturation();
        logic [47:0] vp [3];
        logic        vc [3];
        logic [23:0] vd [3];
        logic        vs [3];
        vp = '{48'h0008_0000_0000, 48'hFE6F_FFEC_0BB1, 48'hFFFF_FFFF_F000};
        vc = '{1'b0, 1'b1, 1'b0};
        vd = '{24'h7FFFFF, 24'h800000, 24'hFFFFFF};
        vs = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            bus.p = vp[i]; bus.carryout = vc[i]; bus.p_valid = 1;
            tick();
            bus.p_valid = 0; bus.carryout = 0;
            tick();
            n_tests++; if (bus.dout !== vd[i]) begin n_fail++; $display("FAIL sat_dout[%0d] got %h want %h", i, bus.dout, vd[i]); end
            n_tests++; if (bus.dout_sat !== vs[i]) begin n_fail++; $display("FAIL sat_flag[%0d] got %b want %b", i, bus.dout_sat, vs[i]); end
            n_tests++; if (bus.dout_carry !== vc[i]) begin n_fail++; $display("FAIL sat_carry[%0d] got %b want %b", i, bus.dout_carry, vc[i]); end
            bus.dout_ready = 1;
            tick();
            bus.dout_ready = 0;
        end
    endtask

    task automatic test_fill_overflow();
        bus.dout_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            bus.p = 48'(k) << 12; bus.p_valid = 1;
            tick();
        end
        bus.p_valid = 0;
        tick();
        tick();
        n_tests++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL fill_level got %0d want 8", bus.level); end
        n_tests++; if (bus.ovf_err !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %b want 1", bus.ovf_err); end
        bus.dout_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            n_tests++; if (bus.dout_valid !== 1'b1 || bus.dout !== 24'(i)) begin n_fail++; $display("FAIL fill_pop[%0d] got v=%b %h want v=1 %h", i, bus.dout_valid, bus.dout, 24'(i)); end
            tick();
        end
        bus.dout_ready = 0;
        n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty_valid got %b want 0", bus.dout_valid); end
        n_tests++; if (bus.dout !== 24'd0) begin n_fail++; $display("FAIL fill_empty_dout got %h want 0", bus.dout); end
    endtask

    task automatic test_error_clear();
        bus.clr_err = 1;
        tick();
        bus.clr_err = 0;
        n_tests++; if (bus.ovf_err !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b want 0", bus.ovf_err); end
        bus.dout_ready = 0;
        for (int k = 1; k <= 9; k++) begin
            bus.p = 48'(k) << 12; bus.p_valid = 1;
            tick();
        end
        bus.p_valid = 0;
        n_tests++; if (bus.ovf_err !== 1'b0 || bus.level !== 4'd8) begin n_fail++; $display("FAIL clr_prefill got ovf=%b lvl=%0d want ovf=0 lvl=8", bus.ovf_err, bus.level); end
        bus.clr_err = 1;
        tick();
        bus.clr_err = 0;
        n_tests++; if (bus.ovf_err !== 1'b1) begin n_fail++; $display("FAIL clr_vs_drop ovf got %b want 1", bus.ovf_err); end
        n_tests++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL clr_drop_level got %0d want 8", bus.level); end
        bus.dout_ready = 1;
        repeat (8) tick();
        bus.dout_ready = 0;
        n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL clr_drain valid got %b want 0", bus.dout_valid); end
    endtask

    task automatic test_async_reset();
        bus.dout_ready = 0;
        for (int k = 1; k <= 5; k++) begin
            bus.p = 48'(k) << 12; bus.p_valid = 1;
            tick();
        end
        bus.p_valid = 0;
        tick();
        n_tests++; if (bus.level !== 4'd5 || bus.ovf_err !== 1'b1) begin n_fail++; $display("FAIL arst_pre got lvl=%0d ovf=%b want lvl=5 ovf=1", bus.level, bus.ovf_err); end
        #2;
        rst_n = 0;
        #1;
        n_tests++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL arst_level got %0d want 0", bus.level); end
        n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b want 0", bus.dout_valid); end
        n_tests++; if (bus.ovf_err !== 1'b0) begin n_fail++; $display("FAIL arst_ovf got %b want 0", bus.ovf_err); end
        n_tests++; if (bus.dout !== 24'd0) begin n_fail++; $display("FAIL arst_dout got %h want 0", bus.dout); end
        #1;
        rst_n = 1;
        bus.p = 48'h1800; bus.p_valid = 1;
        tick();
        bus.p_valid = 0;
        tick();
        n_tests++; if (bus.dout_valid !== 1'b1 || bus.dout !== 24'h2 || bus.level !== 4'd1) begin n_fail++; $display("FAIL arst_first got v=%b %h lvl=%0d want v=1 000002 lvl=1", bus.dout_valid, bus.dout, bus.level); end
        bus.dout_ready = 1;
        tick();
        bus.dout_ready = 0;
    endtask

    task automatic test_full_push_pop();
        int exp;
        int guard;
        bus.dout_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            bus.p = 48'(k) << 12; bus.p_valid = 1;
            tick();
        end
        bus.p_valid = 0;
        tick();
        n_tests++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL full_pre_level got %0d want 8", bus.level); end
        bus.p = 48'(9) << 12; bus.p_valid = 1;
        tick();
        bus.dout_ready = 1;
        exp = 1;
        for (int k = 10; k <= 15; k++) begin
            n_tests++; if (bus.dout !== 24'(exp) || bus.level !== 4'd8) begin n_fail++; $display("FAIL full_pp[%0d] got %h lvl=%0d want %h lvl=8", exp, bus.dout, bus.level, 24'(exp)); end
            bus.p = 48'(k) << 12;
            tick();
            exp++;
        end
        bus.p_valid = 0;
        n_tests++; if (bus.ovf_err !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf got %b want 0", bus.ovf_err); end
        guard = 0;
        while (bus.dout_valid === 1'b1 && guard < 20) begin
            n_tests++; if (bus.dout !== 24'(exp)) begin n_fail++; $display("FAIL full_drain[%0d] got %h want %h", exp, bus.dout, 24'(exp)); end
            tick();
            exp++;
            guard++;
        end
        bus.dout_ready = 0;
        n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_timeout valid got %b want 0", bus.dout_valid); end
        n_tests++; if (exp !== 16) begin n_fail++; $display("FAIL full_pop_count got %0d want 15", exp - 1); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_rounding();
        test_saturation();
        test_fill_overflow();
        test_error_clear();
        test_async_reset();
        test_full_push_pop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
